// File: rtl/mem_wb_pkg.sv
// Shared defines for the MEM/WB stage: bus widths, stall bit indices, reset
// polarity and the registered write-back bundle.
package mem_wb_pkg;

   localparam int RegBus     = 32;
   localparam int RegAddrBus = 5;
   localparam int StallW     = 6;
   localparam int STALL_MEM  = 4;
   localparam int STALL_WB   = 5;

   localparam logic [RegBus-1:0]     ZeroWord     = '0;
   localparam logic [RegAddrBus-1:0] NOPRegAddr   = '0;
   localparam logic                  WriteEnable  = 1'b1;
   localparam logic                  WriteDisable = 1'b0;
   localparam logic                  RstEnable    = 1'b1;

   typedef struct packed {
      logic [RegAddrBus-1:0] wd;
      logic                  wreg;
      logic [RegBus-1:0]     wdata;
      logic                  whilo;
      logic [RegBus-1:0]     hi;
      logic [RegBus-1:0]     lo;
   } wb_t;

   function automatic wb_t wb_bubble();
      wb_t b;
      b.wd    = NOPRegAddr;
      b.wreg  = WriteDisable;
      b.wdata = ZeroWord;
      b.whilo = WriteDisable;
      b.hi    = ZeroWord;
      b.lo    = ZeroWord;
      return b;
   endfunction

endpackage

// File: rtl/llbit_reg.sv
// LLbit storage with a write bypass so MEM sees a pending LL/SC update
// in the same cycle it sits in WB.
module llbit_reg
   import mem_wb_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic flush,
   input  logic we,
   input  logic din,
   output logic dout
);

   logic llbit_q, llbit_d;

   // flush wins over a pending write so an exception always kills the link
   always_comb begin
      llbit_d = llbit_q;
      if (flush)   llbit_d = 1'b0;
      else if (we) llbit_d = din;
   end

   always_ff @(posedge clk) begin
      if (rst == RstEnable) llbit_q <= 1'b0;
      else                  llbit_q <= llbit_d;
   end

   assign dout = we ? din : llbit_q;

endmodule

// File: rtl/mem_wb.sv
// MEM/WB pipeline register with stall/flush handling.
// Define LLBIT_EN to include the LLbit register and its bypass.
module mem_wb
   import mem_wb_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [StallW-1:0]     stall,
   input  logic                  flush,
   input  logic [RegAddrBus-1:0] mem_wd,
   input  logic                  mem_wreg,
   input  logic [RegBus-1:0]     mem_wdata,
   input  logic                  mem_whilo,
   input  logic [RegBus-1:0]     mem_hi,
   input  logic [RegBus-1:0]     mem_lo,
   input  logic                  mem_LLbit_we,
   input  logic                  mem_LLbit_value,
   output logic [RegAddrBus-1:0] wb_wd,
   output logic                  wb_wreg,
   output logic [RegBus-1:0]     wb_wdata,
   output logic                  wb_whilo,
   output logic [RegBus-1:0]     wb_hi,
   output logic [RegBus-1:0]     wb_lo,
   output logic                  LLbit_o
);

   typedef enum logic [1:0] {ACT_LOAD, ACT_BUBBLE, ACT_HOLD} act_e;

   wb_t  wb_q, wb_d, mem_in;
   act_e act;

   assign mem_in = '{wd: mem_wd, wreg: mem_wreg, wdata: mem_wdata,
                     whilo: mem_whilo, hi: mem_hi, lo: mem_lo};

   // MEM stalled while WB runs means nothing valid moves forward: insert a bubble
   always_comb begin
      act = ACT_HOLD;
      if (flush)                 act = ACT_BUBBLE;
      else if (!stall[STALL_MEM]) act = ACT_LOAD;
      else if (!stall[STALL_WB])  act = ACT_BUBBLE;
   end

   always_comb begin
      wb_d = wb_q;
      case (act)
         ACT_LOAD:   wb_d = mem_in;
         ACT_BUBBLE: wb_d = wb_bubble();
         default:    wb_d = wb_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst == RstEnable) wb_q <= wb_bubble();
      else                  wb_q <= wb_d;
   end

   assign wb_wd    = wb_q.wd;
   assign wb_wreg  = wb_q.wreg;
   assign wb_wdata = wb_q.wdata;
   assign wb_whilo = wb_q.whilo;
   assign wb_hi    = wb_q.hi;
   assign wb_lo    = wb_q.lo;

   logic unused_stall;
   assign unused_stall = ^stall[STALL_MEM-1:0];

`ifdef LLBIT_EN
   logic llbit_we_q, llbit_we_d, llbit_value_q, llbit_value_d;

   always_comb begin
      llbit_we_d    = llbit_we_q;
      llbit_value_d = llbit_value_q;
      case (act)
         ACT_LOAD: begin
            llbit_we_d    = mem_LLbit_we;
            llbit_value_d = mem_LLbit_value;
         end
         ACT_BUBBLE: begin
            llbit_we_d    = WriteDisable;
            llbit_value_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         llbit_we_q    <= WriteDisable;
         llbit_value_q <= 1'b0;
      end else begin
         llbit_we_q    <= llbit_we_d;
         llbit_value_q <= llbit_value_d;
      end
   end

   llbit_reg u_llbit (
      .clk  (clk),
      .rst  (rst),
      .flush(flush),
      .we   (llbit_we_q),
      .din  (llbit_value_q),
      .dout (LLbit_o)
   );
`else
   logic unused_llbit;
   assign unused_llbit = mem_LLbit_we ^ mem_LLbit_value;
   assign LLbit_o      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_wb.sv
// Scoreboard bench for mem_wb: directed vectors push hand-computed results,
// a negedge monitor pops and compares them on the cycle they are due.
module tb_mem_wb;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        flush;
   logic [4:0]  mem_wd;
   logic        mem_wreg;
   logic [31:0] mem_wdata;
   logic        mem_whilo;
   logic [31:0] mem_hi, mem_lo;
   logic        mem_LLbit_we, mem_LLbit_value;
   logic [4:0]  wb_wd;
   logic        wb_wreg;
   logic [31:0] wb_wdata;
   logic        wb_whilo;
   logic [31:0] wb_hi, wb_lo;
   logic        LLbit_o;

   mem_wb dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
      .mem_LLbit_we(mem_LLbit_we), .mem_LLbit_value(mem_LLbit_value),
      .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
      .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo), .LLbit_o(LLbit_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      string       name;
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
      logic        whilo;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        ll;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // LLbit expectation collapses to 0 when the feature is compiled out
   function automatic logic llx(input logic b);
`ifdef LLBIT_EN
      return b;
`else
      return 1'b0 & b;
`endif
   endfunction

   task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s: got 0x%08h expected 0x%08h (cycle %0d)", nm, fld, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         exp_t e;
         e = q.pop_front();
         if (e.cyc < cyc) begin
            n_chk++; n_fail++;
            $display("FAIL %s: missed check slot, due %0d now %0d", e.name, e.cyc, cyc);
         end else begin
            chk(e.name, "wb_wd",    {27'd0, wb_wd},    {27'd0, e.wd});
            chk(e.name, "wb_wreg",  {31'd0, wb_wreg},  {31'd0, e.wreg});
            chk(e.name, "wb_wdata", wb_wdata,          e.wdata);
            chk(e.name, "wb_whilo", {31'd0, wb_whilo}, {31'd0, e.whilo});
            chk(e.name, "wb_hi",    wb_hi,             e.hi);
            chk(e.name, "wb_lo",    wb_lo,             e.lo);
            chk(e.name, "LLbit_o",  {31'd0, LLbit_o},  {31'd0, e.ll});
         end
      end
   end

   // drive one cycle of inputs and queue what the outputs must be after the edge
   task automatic step(input string nm, input logic r, input logic [5:0] st, input logic fl,
                       input logic [4:0] wd, input logic wr, input logic [31:0] wdat,
                       input logic wh, input logic [31:0] hi, input logic [31:0] lo,
                       input logic lwe, input logic lval,
                       input logic [4:0] e_wd, input logic e_wr, input logic [31:0] e_wdat,
                       input logic e_wh, input logic [31:0] e_hi, input logic [31:0] e_lo,
                       input logic e_ll);
      exp_t e;
      rst = r; stall = st; flush = fl;
      mem_wd = wd; mem_wreg = wr; mem_wdata = wdat;
      mem_whilo = wh; mem_hi = hi; mem_lo = lo;
      mem_LLbit_we = lwe; mem_LLbit_value = lval;
      e.cyc = cyc + 1; e.name = nm;
      e.wd = e_wd; e.wreg = e_wr; e.wdata = e_wdat;
      e.whilo = e_wh; e.hi = e_hi; e.lo = e_lo; e.ll = e_ll;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   localparam logic [5:0] S0 = 6'b000000, SB = 6'b010000, SH = 6'b110000;

   initial begin
      //   name        rst st fl  wd  wr wdata         wh hi            lo            lwe lv   exp: wd wr wdata        wh hi            lo            ll
      step("reset",    1, S0, 0, 5'd9, 1, 32'hCAFEF00D, 1, 32'h1,        32'h2,        1, 1,  5'd0, 0, 32'h0,        0, 32'h0,        32'h0,        1'b0);
      step("pass",     0, S0, 0, 5'd5, 1, 32'hDEADBEEF, 1, 32'h11,       32'h22,       0, 0,  5'd5, 1, 32'hDEADBEEF, 1, 32'h11,       32'h22,       1'b0);
      step("addr0",    0, S0, 0, 5'd0, 1, 32'hA5A5A5A5, 0, 32'h0,        32'h0,        0, 0,  5'd0, 1, 32'hA5A5A5A5, 0, 32'h0,        32'h0,        1'b0);
      step("bubble",   0, SB, 0, 5'd7, 1, 32'h55,       1, 32'h1,        32'h2,        1, 1,  5'd0, 0, 32'h0,        0, 32'h0,        32'h0,        1'b0);
      step("load1234", 0, S0, 0, 5'd3, 1, 32'h1234,     1, 32'hAA,       32'hBB,       0, 0,  5'd3, 1, 32'h1234,     1, 32'hAA,       32'hBB,       1'b0);
      step("hold1",    0, SH, 0, 5'd9, 1, 32'h1111,     0, 32'h5,        32'h6,        1, 1,  5'd3, 1, 32'h1234,     1, 32'hAA,       32'hBB,       1'b0);
      step("hold2",    0, SH, 0, 5'd10,0, 32'h2222,     1, 32'h7,        32'h8,        0, 0,  5'd3, 1, 32'h1234,     1, 32'hAA,       32'hBB,       1'b0);
      step("hold3",    0, SH, 0, 5'd11,1, 32'h3333,     0, 32'h9,        32'hA,        1, 0,  5'd3, 1, 32'h1234,     1, 32'hAA,       32'hBB,       1'b0);
      step("flushstl", 0, SH, 1, 5'd12,1, 32'h4444,     1, 32'hB,        32'hC,        1, 1,  5'd0, 0, 32'h0,        0, 32'h0,        32'h0,        1'b0);
      step("ll_byp",   0, S0, 0, 5'd2, 1, 32'h100,      0, 32'h0,        32'h0,        1, 1,  5'd2, 1, 32'h100,      0, 32'h0,        32'h0,        llx(1'b1));
      step("ll_reg",   0, S0, 0, 5'd4, 1, 32'h200,      0, 32'h0,        32'h0,        0, 0,  5'd4, 1, 32'h200,      0, 32'h0,        32'h0,        llx(1'b1));
      step("ll_keep",  0, S0, 0, 5'd0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0,  5'd0, 0, 32'h0,        0, 32'h0,        32'h0,        llx(1'b1));
      step("ll_flush", 0, S0, 1, 5'd6, 1, 32'h300,      1, 32'h3,        32'h4,        0, 0,  5'd0, 0, 32'h0,        0, 32'h0,        32'h0,        1'b0);
      step("ll_pend",  0, S0, 0, 5'd1, 1, 32'h400,      0, 32'h0,        32'h0,        1, 1,  5'd1, 1, 32'h400,      0, 32'h0,        32'h0,        llx(1'b1));
      step("fl_pend",  0, S0, 1, 5'd1, 1, 32'h500,      0, 32'h0,        32'h0,        0, 0,  5'd0, 0, 32'h0,        0, 32'h0,        32'h0,        1'b0);
      step("ll_again", 0, S0, 0, 5'd8, 1, 32'h600,      0, 32'h0,        32'h0,        1, 1,  5'd8, 1, 32'h600,      0, 32'h0,        32'h0,        llx(1'b1));
      step("sc_byp",   0, S0, 0, 5'd8, 1, 32'h1,        0, 32'h0,        32'h0,        1, 0,  5'd8, 1, 32'h1,        0, 32'h0,        32'h0,        1'b0);
      step("sc_reg",   0, S0, 0, 5'd0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0,  5'd0, 0, 32'h0,        0, 32'h0,        32'h0,        1'b0);
      step("loadff",   0, S0, 0, 5'd31,1, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1,  5'd31,1, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, llx(1'b1));
      step("holdff",   0, SH, 0, 5'd2, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0,  5'd31,1, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, llx(1'b1));
      step("rst_hold", 1, SH, 1, 5'd2, 1, 32'h77,       1, 32'h7,        32'h7,        1, 1,  5'd0, 0, 32'h0,        0, 32'h0,        32'h0,        1'b0);
      step("post_rst", 0, SH, 0, 5'd2, 1, 32'h77,       1, 32'h7,        32'h7,        1, 1,  5'd0, 0, 32'h0,        0, 32'h0,        32'h0,        1'b0);
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) begin
         n_chk++; n_fail++;
         $display("FAIL drain: %0d expected entries left unchecked, required 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_wb.md
MEM_WB -- requirements
Module: mem_wb

Interface
REQ-001 Parameters: none; all widths come from the shared defines (RegBus = 32, RegAddrBus = 5).
REQ-002 clk  in  1  Single clock; all state updates on the rising edge.
REQ-003 rst  in  1  Reset, synchronous and active-high.
REQ-004 stall  in  6  Pipeline stall vector; bit 4 = MEM, bit 5 = WB.
REQ-005 flush  in  1  Exception flush.
REQ-006 mem_wd / mem_wreg / mem_wdata  in  5/1/32  GPR write address, enable, data from MEM.
REQ-007 mem_whilo / mem_hi / mem_lo  in  1/32/32  HI/LO write enable and data from MEM.
REQ-008 mem_LLbit_we / mem_LLbit_value  in  1/1  LLbit write request from MEM (LL sets, SC clears).
REQ-009 wb_wd / wb_wreg / wb_wdata  out  5/1/32  Registered GPR write port; drives the register-file write port.
REQ-010 wb_whilo / wb_hi / wb_lo  out  1/32/32  Registered HI/LO write port.
REQ-011 LLbit_o  out  1  Current LLbit as seen by MEM, including WB bypass.

Function
REQ-012 All wb_* outputs SHALL be registered, with one cycle of latency from mem_* to wb_*.
REQ-013 If stall[4]=0, the block SHALL capture all mem_* inputs on the edge.
REQ-014 If stall[4]=1 and stall[5]=0, the block SHALL load a bubble: wb_wd=0, wb_wreg=0, wb_wdata=0, wb_whilo=0, wb_hi=0, wb_lo=0, internal LLbit_we=0.
REQ-015 If stall[4]=1 and stall[5]=1, the block SHALL hold all registered outputs unchanged.
REQ-016 If flush=1, the block SHALL load a bubble regardless of stall.
REQ-017 flush SHALL take priority over stall.
REQ-018 A write to address 0 SHALL pass through unchanged; the register file suppresses it.
REQ-019 The LLbit register SHALL update on the edge when the registered LLbit_we=1, taking the registered LLbit_value.
REQ-020 LLbit_o SHALL equal the registered LLbit_value while the registered LLbit_we=1, and the LLbit register otherwise.
REQ-021 flush=1 SHALL clear the LLbit register to 0 on that edge, overriding a pending LLbit write.
REQ-022 Back-to-back LL then SC SHALL be handled as follows: the SC in MEM sees LLbit_o=1 through the REQ-020 bypass.

Reset
REQ-023 When rst=1 at a rising edge, all wb_* outputs SHALL be 0, the internal LLbit_we and LLbit_value SHALL be 0, and the LLbit register SHALL be 0.
REQ-024 rst SHALL override flush and stall.
REQ-025 Reset asserted mid-stall SHALL discard the held contents.

Configuration
REQ-026 Macro LLBIT_EN defined: the LLbit register, its bypass, and the mem_LLbit_* ports SHALL be present, with behaviour per REQ-019 to REQ-022.
REQ-027 Macro LLBIT_EN undefined: the LLbit logic SHALL be removed, mem_LLbit_* SHALL be ignored, and LLbit_o SHALL be tied to 0.
REQ-028 GPR and HI/LO behaviour SHALL be identical with or without LLBIT_EN.

Structure
REQ-029 Stall bit indices, ZeroWord, NOPRegAddr, WriteEnable/WriteDisable, and RstEnable SHALL come from the shared defines file.
REQ-030 The LLbit storage and bypass SHALL be the sub-module llbit_reg (clk, rst, flush, we, din, dout).
REQ-031 llbit_reg SHALL be instantiated only under LLBIT_EN.

Verification
REQ-032 Pass-through: mem_wd=5, mem_wreg=1, mem_wdata=0xDEADBEEF, stall=0 -> next cycle wb_wd=5, wb_wreg=1, wb_wdata=0xDEADBEEF.
REQ-033 Bubble: stall=6'b010000 with valid mem_* -> wb_wreg=0, wb_whilo=0, wb_wdata=0.
REQ-034 Hold: load wb_wdata=0x1234, then stall=6'b110000 for 3 cycles with changing mem_* -> wb_wdata stays 0x1234 all 3 cycles.
REQ-035 Flush vs. stall: flush=1 with stall=6'b110000 and wb_wreg=1 held -> next cycle all wb_*=0, and the LLbit register = 0.
REQ-036 LL/SC (LLBIT_EN): cycle n mem_LLbit_we=1, value=1 -> cycle n+1 LLbit_o=1 via bypass; cycle n+2 LLbit_o=1 from the register; with flush at n+3 -> LLbit_o=0 at n+4.
REQ-037 Reset: rst=1 during a hold stall with wb_wdata=0xFFFFFFFF -> next cycle all outputs 0 and LLbit_o=0; without LLBIT_EN, LLbit_o=0 in every cycle.
